console_uart_tx: RTL
====================

# console_uart_tx

Memory-mapped console transmitter on the RV32I core's data-memory write port, alongside data memory. It captures stores to the console address, buffers the low byte in a small FIFO, and serializes bytes as 8N1 UART frames on `tx`. It is the hardware replacement for the simulation-only console print, so console output also works on FPGA builds. A status word, readable at a second address, reports FIFO state and overflow drops.

## Interface
- `CONSOLE_ADDR`, 32'h0000_FFFC (65532): store address whose data byte is transmitted.
- `STATUS_ADDR`, 32'h0000_FFF8 (65528): status read address; a store here clears `drop_count`.
- `CLKS_PER_BIT`, 16: clocks per UART bit, must be ≥2.
- `FIFO_DEPTH`, 8: byte FIFO depth, power of 2, ≥2.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  32  core data address.
- `writedata`  in  32  store data; only [7:0] is used.
- `status_rdata`  out  32  combinational; the status word when `dataadr==STATUS_ADDR`, else 0.
- `tx`  out  1  UART serial output, idle high.
- `tx_busy`  out  1  high while the FSM is not in IDLE.
- `fifo_full`  out  1  FIFO occupancy equals `FIFO_DEPTH`.
- `fifo_empty`  out  1  FIFO occupancy is 0.
- `drop_count`  out  8  saturating count of bytes dropped on a full FIFO.

## Operation
- **Push:** at a rising edge with `memwrite && dataadr==CONSOLE_ADDR`.
  - The byte `writedata[7:0]` is written if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `drop_count` increments, saturating at 255.
- **Clear:** `memwrite && dataadr==STATUS_ADDR` clears `drop_count`. Nothing is pushed.
- **Other addresses:** stores to any other address are ignored.
- **FIFO:** read/write pointers of width log2(FIFO_DEPTH)+1; wraps modulo depth.
  - Simultaneous push and pop on a full FIFO: occupancy stays at depth and no drop is counted.
  - Simultaneous push and pop on an empty FIFO cannot occur, because a pop needs a non-empty FIFO.
- **Status word:** [0] fifo_full, [1] fifo_empty, [2] tx_busy, [15:8] drop_count, [19:16] occupancy (zero-extended), all other bits 0.
- **TX FSM:** states IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) drive it.
  - IDLE, FIFO non-empty: pop the head byte into the shift register, go to START. `tx` stays 1 while in IDLE.
  - START: `tx`=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: shift out 8 bits LSB first, each held for CLKS_PER_BIT clocks, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT clocks. On the last STOP clock, if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- **tx register:** `tx` is driven from a flop, never combinationally from the FSM.

## Timing
- **Reset values:** `tx`=1, FSM=IDLE, FIFO empty (`fifo_empty`=1, `fifo_full`=0), `tx_busy`=0, `drop_count`=0, all counters 0.
- **Reset mid-frame:** the frame is aborted, the FIFO is flushed, and `tx`=1 after the reset edge. A push in the reset cycle is lost.
- **Latency:** a push at edge N gives a pop at edge N+1. `tx` is low from edge N+1 to N+1+CLKS_PER_BIT.
- **Frame length:** 10×CLKS_PER_BIT clocks. Back-to-back frames are contiguous.
- **Flag timing:** `tx_busy` asserts at edge N+1 and deasserts at the edge ending STOP when the FIFO is empty. `fifo_full`, `fifo_empty` and `drop_count` update at the push/pop edge.
- **Throughput:** one push accepted per cycle.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- **Reset:** hold `reset`=1 for 3 cycles, with `memwrite`=1 to CONSOLE_ADDR during reset → `tx`=1, `fifo_empty`=1, `drop_count`=0, `tx_busy`=0. No push occurs.
- **Single byte:** store 0x0000_0041 to 65532 at edge N → `tx` samples 0,1,0,0,0,0,0,1,0,1, each bit 4 clocks, starting at edge N+1. `tx_busy` falls at edge N+41.
- **Burst overflow:** 10 consecutive stores 0x30..0x39, one per cycle from edge N.
  - `fifo_full`=1 after edge N+8.
  - 0x39 is dropped and `drop_count`=1.
  - 0x30..0x38 are sent back-to-back, 360 clocks total with no gaps.
- **Address decode/clear:** store to 0x0000_1000 → no push. Then store to 65528 → `drop_count`=0. Read with `dataadr`=65528 → `status_rdata`=0x0000_0002 when idle and empty.
- **Full+pop race:** with the FIFO full, push on the final STOP clock → accepted, occupancy stays 8, `drop_count` unchanged.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 4 bytes queued → `tx`=1 next edge, `fifo_empty`=1, and no further frames.

Source files
------------

// File: rtl/console_uart_tx.sv
// Console store port -> byte FIFO -> 8N1 serializer; push at edge N starts START at edge N+1.
// Never stalls the core: stores to a full FIFO are dropped and counted (saturating) in drop_count.
module console_uart_tx #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_FFFC,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_FFF8,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] status_rdata,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_P   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, occ;
  logic [3:0]    occ4;
  logic          push_req, clr_req, push, pop, drop, baud_done;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  assign occ        = wr_ptr - rd_ptr;
  assign occ4       = 4'(occ);
  assign fifo_full  = (occ == DEPTH_P);
  assign fifo_empty = (occ == '0);
  assign tx_busy    = (state != IDLE);
  assign baud_done  = (baud_cnt == BAUD_LAST);

  assign push_req = memwrite && (dataadr == CONSOLE_ADDR);
  assign clr_req  = memwrite && (dataadr == STATUS_ADDR);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && !push;

  assign status_rdata = (dataadr == STATUS_ADDR) ?
                        {12'd0, occ4, drop_count, 5'd0, tx_busy, fifo_empty, fifo_full} : 32'd0;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_n    = mem[rd_ptr[AW-1:0]];
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr[AW-1:0]];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (clr_req)
        drop_count <= '0;
      else if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= writedata[7:0];
  end

endmodule
